// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: controller state encoding and
// the default sizing of the shared down-counter and the requester count.
package timer_sched_pkg;

    // Default bit width of the shared down-counter.
    localparam int WIDTH_DEFAULT = 4;

    // Default number of requesters competing for the timer.
    localparam int NREQ_DEFAULT  = 2;

    // Controller states. IDLE arbitrates, RUN counts down for the owner,
    // DONE is the single cycle that carries the expiry pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : timer_sched_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts one position above the
// previous owner and wraps, so the most recent owner has the lowest priority.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_owner_i,
    output logic [NREQ-1:0] winner_o,
    output logic            valid_o
);

    logic [IDXW-1:0] cand;

    // Walk candidates (last_owner+1 .. last_owner+NREQ) mod NREQ; first live request wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(last_owner_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                winner_o[cand] = 1'b1;
                valid_o        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/timer_sched.sv
// Shared-timer scheduler. Requesters compete round-robin for a single
// down-counter; the owner keeps it until the count expires (done pulse) or
// it withdraws its request (abort).
//
// Handshake: req[i] is a level that requester i holds until it sees done[i]
// or decides to abort by dropping it. gnt[i] stays high for the whole time i
// owns the counter; done[i] is a one-cycle pulse on the cycle right after the
// last gnt[i] cycle. Non-owner requests are only looked at in IDLE, never
// queued.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int NREQ  = NREQ_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count_out,
    output state_e                state_o
);

    localparam int              IDXW     = $clog2(NREQ);
    // Resetting the pointer to the top index makes requester 0 win first.
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic              busy_q,  busy_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [IDXW-1:0]   last_q,  last_d;

    logic [NREQ-1:0]   win_onehot;
    logic              win_valid;
    logic [IDXW-1:0]   win_idx;
    logic [WIDTH-1:0]  win_load;
    logic              owner_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req_i        (req),
        .last_owner_i (last_q),
        .winner_o     (win_onehot),
        .valid_o      (win_valid)
    );

    // Encode the one-hot winner to an index and pick its start value.
    always_comb begin
        win_idx  = '0;
        win_load = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_idx  = IDXW'(i);
                win_load = load_val[i*WIDTH +: WIDTH];
            end
        end
    end

    // The owner is still interested while its own request bit stays high.
    assign owner_req = |(req & gnt_q);

    // Next-state and registered-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = RUN;
                    gnt_d   = win_onehot;
                    count_d = win_load;
                    last_d  = win_idx;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    // Abort: release the counter silently, keep last owner.
                    state_d = IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (count_q == '0) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign count_out = count_q;
    assign state_o   = state_q;

endmodule : timer_sched

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed scenarios with literal expectations, then a
// long random run compared cycle by cycle against a behavioural model.
module tb_timer_sched;
    import timer_sched_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] load_val = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count_out;
    state_e                state_dbg;

    int n_vec = 0;
    int n_err = 0;

    timer_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .load_val  (load_val),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .count_out (count_out),
        .state_o   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_load(input int i, input int v);
        load_val[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    // ---------------- behavioural model ----------------
    // Owner index (-1 none), remaining count, requester receiving the expiry
    // pulse (-1 none) and the round-robin pointer.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_done  = -1;
    int m_last  = NREQ - 1;
    int m_cand;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_done  = -1;
            m_last  = NREQ - 1;
        end else if (m_done >= 0) begin
            m_done = -1;
        end else if (m_owner >= 0) begin
            if (req[m_owner]) begin
                if (m_cnt == 0) begin
                    m_done  = m_owner;
                    m_owner = -1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                m_cand = (m_last + k) % NREQ;
                if (req[m_cand]) begin
                    m_owner = m_cand;
                    m_last  = m_cand;
                    m_cnt   = int'(load_val[m_cand*WIDTH +: WIDTH]);
                    break;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [NREQ-1:0]  prev_gnt = '0;
    logic [WIDTH-1:0] prev_cnt = '0;
    logic             prev_run = 1'b0;
    int               wait_cnt [NREQ];
    logic [NREQ-1:0]  exp_gnt;
    logic [NREQ-1:0]  exp_done;
    logic             new_grant;

    always @(negedge clk) begin
        exp_gnt  = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        exp_done = (m_done  >= 0) ? NREQ'(1 << m_done)  : '0;
        check("gnt",       gnt,       exp_gnt);
        check("done",      done,      exp_done);
        check("busy",      busy,      (m_owner >= 0) || (m_done >= 0));
        check("count_out", count_out, m_cnt);
        check("gnt_onehot0",  $onehot0(gnt),  1);
        check("done_onehot0", $onehot0(done), 1);
        check("done_after_gnt", (done & ~prev_gnt) == '0, 1);
        if (prev_run && state_dbg == RUN && gnt != '0 && gnt == prev_gnt)
            check("count_nonincr", count_out <= prev_cnt, 1);
        new_grant = (gnt != '0) && (prev_gnt == '0);
        for (int i = 0; i < NREQ; i++) begin
            if (reset || !req[i]) begin
                wait_cnt[i] = 0;
            end else if (new_grant) begin
                if (gnt[i]) begin
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i] = wait_cnt[i] + 1;
                    check("no_starve", wait_cnt[i] <= NREQ - 1, 1);
                end
            end
        end
        prev_gnt = gnt;
        prev_cnt = count_out;
        prev_run = (state_dbg == RUN);
    end

    // ---------------- stimulus ----------------
    int          gseq[$];
    logic [NREQ-1:0] pg;
    int          budget;

    initial begin
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

        // Reset state.
        reset = 1'b1; req = '0; load_val = '0;
        tick(); tick();
        check("rst_gnt",   gnt,       0);
        check("rst_done",  done,      0);
        check("rst_busy",  busy,      0);
        check("rst_count", count_out, 0);

        // Single timer of 3: grant, 2,1,0, done, then idle.
        reset = 1'b0; req = 2'b01; set_load(0, 3);
        tick();
        check("r28_gnt",   gnt,       2'b01);
        check("r28_cnt",   count_out, 3);
        check("r28_model", m_cnt,     3);
        for (int v = 2; v >= 0; v--) begin
            tick();
            check("r28_cnt_dec", count_out, v);
            check("r28_gnt_hold", gnt, 2'b01);
        end
        tick();
        check("r28_done",      done, 2'b01);
        check("r28_gnt_clear", gnt,  2'b00);
        check("r28_busy_done", busy, 1);
        req = 2'b00;
        tick();
        check("r28_done_pulse", done, 2'b00);
        check("r28_busy_low1",  busy, 0);
        tick();
        check("r28_busy_low2",  busy, 0);

        // Both requesting: grants alternate 0,1,0,1.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 2'b11; set_load(0, 2); set_load(1, 1);
        pg = '0; budget = 0; gseq.delete();
        while (gseq.size() < 4 && budget < 60) begin
            tick();
            budget++;
            if (gnt != '0 && pg == '0) gseq.push_back(int'(gnt));
            if (done != '0) check("r29_done_match", done, pg);
            pg = gnt;
        end
        check("r29_in_budget", budget < 60, 1);
        for (int k = 0; k < 4; k++)
            check("r29_order", (gseq.size() > k) ? gseq[k] : 0, (k % 2 == 0) ? 1 : 2);
        req = 2'b00;
        tick(); tick(); tick();

        // Zero load: done on the cycle after grant, count stays 0.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 2'b01; set_load(0, 0);
        tick();
        check("r30_gnt", gnt, 2'b01);
        check("r30_cnt", count_out, 0);
        tick();
        check("r30_done", done, 2'b01);
        check("r30_cnt0", count_out, 0);
        req = 2'b00;
        tick();
        check("r30_done_off", done, 2'b00);

        // Abort at count 3; load change mid-run must not matter.
        req = 2'b01; set_load(0, 5);
        tick();
        check("r31_cnt5", count_out, 5);
        set_load(0, 15);
        tick();
        check("r31_cnt4", count_out, 4);
        tick();
        check("r31_cnt3", count_out, 3);
        req = 2'b00;
        tick();
        check("r31_gnt",  gnt,       0);
        check("r31_cnt",  count_out, 0);
        check("r31_busy", busy,      0);
        check("r31_done", done,      0);
        tick();
        check("r31_no_done", done, 0);

        // Reset in RUN at count 2; requester 1 wins on first edge after release.
        req = 2'b01; set_load(0, 3); set_load(1, 6);
        tick(); tick();
        check("r32_cnt2", count_out, 2);
        reset = 1'b1; req = 2'b10;
        #1;
        check("r32_rst_gnt",  gnt,       0);
        check("r32_rst_done", done,      0);
        check("r32_rst_busy", busy,      0);
        check("r32_rst_cnt",  count_out, 0);
        tick();
        reset = 1'b0;
        tick();
        check("r32_gnt1", gnt,       2'b10);
        check("r32_cnt6", count_out, 6);
        req = 2'b00;
        tick();
        check("r32_abort_busy", busy, 0);

        // Random run against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
                    else if (done[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 1) == 1)
                    set_load(i, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
            end
            tick();
        end

        reset = 1'b0; req = '0;
        tick(); tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_timer_sched
